// File: rtl/lvds_frame_parse_if.sv
// Byte stream from the LVDS deserialiser in, framed payload and status out.
// The master modport is the stream source and sink; the slave modport is the parser.
interface lvds_frame_parse_if;
  logic [8:0]  s2p_dout;
  logic        dout_en;
  logic [7:0]  frm_data;
  logic        frm_vld;
  logic        frm_sop;
  logic        frm_eop;
  logic [11:0] frm_len;
  logic        frm_done;
  logic        frm_ok;
  logic [15:0] err_cnt;

  modport master (
    output s2p_dout, dout_en,
    input  frm_data, frm_vld, frm_sop, frm_eop, frm_len, frm_done, frm_ok, err_cnt
  );

  modport slave (
    input  s2p_dout, dout_en,
    output frm_data, frm_vld, frm_sop, frm_eop, frm_len, frm_done, frm_ok, err_cnt
  );
endinterface

// File: rtl/lvds_frame_parse.sv
// Frame parser: SYNC0 SYNC1 LEN_H LEN_L payload checksum, registered outputs.
// Define LVDS_FRAME_PARSE_ERRCNT_EN to build the saturating bad-frame counter.
//
// state   | meaning
// HUNT    | idle, waiting for SYNC0
// SYNC    | SYNC0 seen, expecting SYNC1
// LEN_H   | expecting length high nibble byte
// LEN_L   | expecting length low byte, length checked here
// PAYLOAD | forwarding payload bytes, r_rem counts down to 1
// CHK     | expecting checksum byte
module lvds_frame_parse #(
  parameter logic [7:0]  SYNC0   = 8'hEB,
  parameter logic [7:0]  SYNC1   = 8'h90,
  parameter logic [11:0] MAX_LEN = 12'd1024
) (
  input logic                clk_m_144,
  input logic                rst_n,
  lvds_frame_parse_if.slave  bus
);

  typedef enum logic [2:0] {HUNT, SYNC, LEN_H, LEN_L, PAYLOAD, CHK} state_t;

  state_t      r_state, w_state_nxt;
  logic        w_acc;
  logic [7:0]  w_byte;
  logic [11:0] w_len_cand;
  logic [3:0]  r_len_h, w_len_h_nxt;
  logic [11:0] r_len, w_len_nxt;
  logic [11:0] r_rem, w_rem_nxt;
  logic [7:0]  r_sum, w_sum_nxt;
  logic [7:0]  r_data, w_data_nxt;
  logic        r_vld, w_vld_nxt;
  logic        r_sop, w_sop_nxt;
  logic        r_eop, w_eop_nxt;
  logic        r_done, w_done_nxt;
  logic        r_ok, w_ok_nxt;

  assign w_acc      = bus.s2p_dout[8] & bus.dout_en;
  assign w_byte     = bus.s2p_dout[7:0];
  assign w_len_cand = {r_len_h, w_byte};

  always_ff @(posedge clk_m_144) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_len_h <= '0;
      r_len   <= '0;
      r_rem   <= '0;
      r_sum   <= '0;
      r_data  <= '0;
      r_vld   <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_done  <= 1'b0;
      r_ok    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len_h <= w_len_h_nxt;
      r_len   <= w_len_nxt;
      r_rem   <= w_rem_nxt;
      r_sum   <= w_sum_nxt;
      r_data  <= w_data_nxt;
      r_vld   <= w_vld_nxt;
      r_sop   <= w_sop_nxt;
      r_eop   <= w_eop_nxt;
      r_done  <= w_done_nxt;
      r_ok    <= w_ok_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_len_h_nxt = r_len_h;
    w_len_nxt   = r_len;
    w_rem_nxt   = r_rem;
    w_sum_nxt   = r_sum;
    w_data_nxt  = r_data;
    w_vld_nxt   = 1'b0;
    w_sop_nxt   = 1'b0;
    w_eop_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    w_ok_nxt    = r_ok;

    // Any gap in the stream once a frame has started kills it.
    if (r_state != HUNT && !w_acc) begin
      if (r_state == PAYLOAD && r_rem != r_len) begin
        w_vld_nxt  = 1'b1;
        w_eop_nxt  = 1'b1;
        w_data_nxt = 8'h00;
      end
      w_done_nxt  = 1'b1;
      w_ok_nxt    = 1'b0;
      w_state_nxt = HUNT;
    end else if (w_acc) begin
      case (r_state)
        HUNT: begin
          if (w_byte == SYNC0) w_state_nxt = SYNC;
        end
        SYNC: begin
          if (w_byte == SYNC1)      w_state_nxt = LEN_H;
          else if (w_byte != SYNC0) w_state_nxt = HUNT;
        end
        LEN_H: begin
          w_sum_nxt   = w_byte;
          w_len_h_nxt = w_byte[3:0];
          if (w_byte[7:4] != 4'h0) begin
            w_done_nxt  = 1'b1;
            w_ok_nxt    = 1'b0;
            w_state_nxt = HUNT;
          end else begin
            w_state_nxt = LEN_L;
          end
        end
        LEN_L: begin
          w_sum_nxt = r_sum + w_byte;
          w_len_nxt = w_len_cand;
          w_rem_nxt = w_len_cand;
          if (w_len_cand == 12'd0 || w_len_cand > MAX_LEN) begin
            w_done_nxt  = 1'b1;
            w_ok_nxt    = 1'b0;
            w_state_nxt = HUNT;
          end else begin
            w_state_nxt = PAYLOAD;
          end
        end
        PAYLOAD: begin
          w_sum_nxt  = r_sum + w_byte;
          w_data_nxt = w_byte;
          w_vld_nxt  = 1'b1;
          w_sop_nxt  = (r_rem == r_len);
          w_eop_nxt  = (r_rem == 12'd1);
          w_rem_nxt  = r_rem - 12'd1;
          if (r_rem == 12'd1) w_state_nxt = CHK;
        end
        CHK: begin
          w_done_nxt  = 1'b1;
          w_ok_nxt    = (w_byte == r_sum);
          w_state_nxt = HUNT;
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  assign bus.frm_data = r_data;
  assign bus.frm_vld  = r_vld;
  assign bus.frm_sop  = r_sop;
  assign bus.frm_eop  = r_eop;
  assign bus.frm_len  = r_len;
  assign bus.frm_done = r_done;
  assign bus.frm_ok   = r_ok;

`ifdef LVDS_FRAME_PARSE_ERRCNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk_m_144) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (r_done && !r_ok && r_err_cnt != 16'hFFFF) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign bus.err_cnt = r_err_cnt;
`else
  assign bus.err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_lvds_frame_parse.sv
// Directed bench for lvds_frame_parse: good, bad-checksum, sync-slip, length-error,
// truncation, mid-frame reset and back-to-back frames.
module tb_lvds_frame_parse;
  logic clk_m_144;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  lvds_frame_parse_if bus ();

  lvds_frame_parse dut (
    .clk_m_144 (clk_m_144),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  initial clk_m_144 = 1'b0;
  always #5 clk_m_144 = ~clk_m_144;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input, then check the registered response to it.
  task automatic step(input string tag, input logic v, input logic [7:0] b,
                      input logic e_vld, input logic e_sop, input logic e_eop,
                      input logic [7:0] e_data, input logic e_done, input logic e_ok);
    bus.s2p_dout = {v, b};
    bus.dout_en  = v;
    @(posedge clk_m_144);
    #1;
    check({tag, ".vld"},  {15'd0, bus.frm_vld},  {15'd0, e_vld});
    check({tag, ".sop"},  {15'd0, bus.frm_sop},  {15'd0, e_sop});
    check({tag, ".eop"},  {15'd0, bus.frm_eop},  {15'd0, e_eop});
    check({tag, ".done"}, {15'd0, bus.frm_done}, {15'd0, e_done});
    if (e_vld)  check({tag, ".data"}, {8'd0, bus.frm_data}, {8'd0, e_data});
    if (e_done) check({tag, ".ok"},   {15'd0, bus.frm_ok},  {15'd0, e_ok});
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic hdr(input string tag, input logic [7:0] lh, input logic [7:0] ll);
    step({tag, ".s0"}, 1'b1, 8'hEB, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step({tag, ".s1"}, 1'b1, 8'h90, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step({tag, ".lh"}, 1'b1, lh,    1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic good_frame(input string tag, input logic [7:0] ck, input logic e_ok);
    hdr(tag, 8'h00, 8'h03);
    step({tag, ".ll"}, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check({tag, ".len"}, {4'd0, bus.frm_len}, 16'd3);
    step({tag, ".p1"}, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    step({tag, ".p2"}, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0);
    step({tag, ".p3"}, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
    step({tag, ".ck"}, 1'b1, ck,    1'b0, 1'b0, 1'b0, 8'h00, 1'b1, e_ok);
  endtask

  initial begin
    logic [15:0] e_err;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.s2p_dout = 9'h000;
    bus.dout_en  = 1'b0;
    repeat (2) @(posedge clk_m_144);
    #1;
    check("rst.data", {8'd0, bus.frm_data}, 16'h0);
    check("rst.vld",  {15'd0, bus.frm_vld}, 16'h0);
    check("rst.len",  {4'd0, bus.frm_len},  16'h0);
    check("rst.done", {15'd0, bus.frm_done}, 16'h0);
    check("rst.ok",   {15'd0, bus.frm_ok},  16'h0);
    check("rst.err",  bus.err_cnt,          16'h0);
    rst_n = 1'b1;
    idle("rst.idle");

    good_frame("good", 8'h69, 1'b1);
    idle("good.idle");
    check("good.ok_hold", {15'd0, bus.frm_ok}, 16'h1);
    check("good.err", bus.err_cnt, 16'h0);

    good_frame("badck", 8'h6A, 1'b0);
    idle("badck.idle");
`ifdef LVDS_FRAME_PARSE_ERRCNT_EN
    e_err = 16'd1;
`else
    e_err = 16'd0;
`endif
    check("badck.err", bus.err_cnt, e_err);

    step("slip.55", 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("slip.eb", 1'b1, 8'hEB, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    hdr("slip", 8'h00, 8'h01);
    step("slip.ll", 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("slip.len", {4'd0, bus.frm_len}, 16'd1);
    step("slip.p1", 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    step("slip.ck", 1'b1, 8'hA6, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    idle("slip.idle");

    hdr("lenbig", 8'h04, 8'h01);
    step("lenbig.ll", 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle("lenbig.idle");
    hdr("len0", 8'h00, 8'h00);
    step("len0.ll", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle("len0.idle");

    hdr("trunc", 8'h00, 8'h03);
    step("trunc.ll", 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("trunc.p1", 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    step("trunc.p2", 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0);
    step("trunc.cut", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    idle("trunc.idle");
`ifdef LVDS_FRAME_PARSE_ERRCNT_EN
    e_err = 16'd4;
`else
    e_err = 16'd0;
`endif
    check("trunc.err", bus.err_cnt, e_err);

    hdr("kill", 8'h00, 8'h03);
    step("kill.ll", 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("kill.p1", 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    rst_n = 1'b0;
    bus.s2p_dout = 9'h122;
    bus.dout_en  = 1'b1;
    @(posedge clk_m_144);
    #1;
    check("kill.rst.data", {8'd0, bus.frm_data}, 16'h0);
    check("kill.rst.vld",  {15'd0, bus.frm_vld}, 16'h0);
    check("kill.rst.sop",  {15'd0, bus.frm_sop}, 16'h0);
    check("kill.rst.len",  {4'd0, bus.frm_len},  16'h0);
    check("kill.rst.done", {15'd0, bus.frm_done}, 16'h0);
    check("kill.rst.ok",   {15'd0, bus.frm_ok},  16'h0);
    check("kill.rst.err",  bus.err_cnt,          16'h0);
    rst_n = 1'b1;
    idle("kill.idle");
    idle("kill.idle2");

    good_frame("after", 8'h69, 1'b1);
    hdr("b2b", 8'h00, 8'h02);
    step("b2b.ll", 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("b2b.len", {4'd0, bus.frm_len}, 16'd2);
    step("b2b.p1", 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
    step("b2b.p2", 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
    step("b2b.ck", 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    idle("b2b.idle");
    check("b2b.data_hold", {8'd0, bus.frm_data}, 16'h0002);
    check("b2b.err", bus.err_cnt, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lvds_frame_parse.md
LVDS_FRAME_PARSE -- requirements
Module: lvds_frame_parse

Interface
REQ-001 Parameter SYNC0, default 8'hEB, first sync byte of a frame.
REQ-002 Parameter SYNC1, default 8'h90, second sync byte of a frame.
REQ-003 Parameter MAX_LEN, default 12'd1024, largest legal payload length in bytes.
REQ-004 Port clk_m_144, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port s2p_dout, input, 9 bits: bit 8 is the byte valid; bits [7:0] are the byte, already bit-ordered.
REQ-007 Port dout_en, input, 1 bit: the upstream frame window; high while a burst is being delivered.
REQ-008 Port frm_data, output, 8 bits: the payload byte.
REQ-009 Port frm_vld, output, 1 bit: frm_data is valid this cycle.
REQ-010 Port frm_sop, output, 1 bit: marks the first payload byte; asserted together with frm_vld.
REQ-011 Port frm_eop, output, 1 bit: marks the last payload byte; asserted together with frm_vld.
REQ-012 Port frm_len, output, 12 bits: the declared payload length, held from the LEN_L byte until the next frame.
REQ-013 Port frm_done, output, 1 bit: one-cycle pulse on the checksum byte or on an abort.
REQ-014 Port frm_ok, output, 1 bit: qualified by frm_done; 1 means the checksum matched.
REQ-015 Port err_cnt, output, 16 bits: saturating count of bad frames.

Function
REQ-016 An input byte is accepted only in a cycle where s2p_dout[8]=1 and dout_en=1.
REQ-017 The FSM states are HUNT, SYNC, LEN_H, LEN_L, PAYLOAD, CHK.
- HUNT goes to SYNC on an accepted byte equal to SYNC0.
- SYNC goes to LEN_H on SYNC1.
- SYNC stays in SYNC on SYNC0.
- SYNC goes to HUNT on any other byte.
REQ-018 LEN_H captures len[11:8] from byte[3:0]; byte[7:4] must be 0, otherwise the frame is a length error.
REQ-019 LEN_L captures len[7:0]. If len==0 or len>MAX_LEN, the block raises a length error; otherwise it goes to PAYLOAD.
REQ-020 In PAYLOAD, each accepted byte is output with exactly 1 cycle of latency (registered outputs).
- frm_sop is asserted on byte 1.
- frm_eop is asserted on byte len.
- After byte len, the FSM goes to CHK.
REQ-021 The checksum is the 8-bit modulo-256 sum of the LEN_H byte, the LEN_L byte and every payload byte.
REQ-022 In CHK, the next accepted byte is compared with the sum, and the FSM returns to HUNT.
- frm_done=1 one cycle after the CHK byte.
- frm_ok=1 if the byte equals the sum.
REQ-023 An abort occurs when, outside HUNT, s2p_dout[8]=0 or dout_en=0.
- If the FSM is in PAYLOAD and at least one byte has been output, frm_vld and frm_eop pulse with frm_data=8'h00 to close the packet.
- In all abort cases: frm_done=1, frm_ok=0, and the FSM returns to HUNT.
REQ-024 A length error gives frm_done=1 and frm_ok=0 one cycle later, and the FSM returns to HUNT; frm_vld stays 0.
REQ-025 Bytes between frames are ignored in HUNT; frames may be back-to-back, with SYNC0 immediately following the CHK byte.
REQ-026 frm_vld, frm_sop, frm_eop and frm_done are single-cycle pulses. frm_ok and frm_data hold their value until they are next written.

Reset
REQ-027 While rst_n=0 at a clock edge, the block is reset:
- the FSM is set to HUNT;
- frm_data=0, frm_vld=0, frm_sop=0, frm_eop=0, frm_len=0, frm_done=0, frm_ok=0, err_cnt=0;
- the checksum and byte counter are cleared.
REQ-028 A reset taken mid-frame discards the frame with no frm_done pulse; parsing restarts in HUNT on the first cycle with rst_n=1.

Configuration
REQ-029 Macro LVDS_FRAME_PARSE_ERRCNT_EN selects the error counter.
- Defined: err_cnt increments by 1 on each frm_done with frm_ok=0, and saturates at 16'hFFFF.
- Undefined: err_cnt is a constant 0 and no counter is synthesised.

Verification
REQ-030 Good frame: EB 90 00 03 11 22 33 69 sent contiguously.
- Response: frm_data 11/22/33 with frm_sop on 11 and frm_eop on 33, and frm_len=3.
- Next cycle: frm_done=1, frm_ok=1.
REQ-031 Bad checksum: the same frame with the checksum byte 6A.
- Response: the payload is output as before, then frm_done=1 and frm_ok=0; err_cnt goes 0 to 1 when the macro is defined, and stays 0 when it is undefined.
REQ-032 Sync slip: the sequence 55 EB EB 90 00 01 A5 A6.
- Response: a single payload byte A5 with frm_sop=frm_eop=1, then frm_ok=1.
REQ-033 Length error: EB 90 04 01 ... (length 0x401 exceeds 1024), and separately EB 90 00 00.
- Response: no frm_vld; frm_done=1 and frm_ok=0 one cycle after the LEN_L byte.
REQ-034 Truncation: s2p_dout[8] drops after payload byte 2 of a 3-byte frame.
- Response: a closing frm_eop with data 00, frm_done=1, frm_ok=0, and the FSM returns to HUNT.
REQ-035 Reset mid-payload: rst_n=0 for 1 cycle, then a good frame is sent.
- Response: all outputs are 0 during reset, there is no frm_done for the killed frame, and the second frame gives frm_ok=1.
